// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants and receiver state encoding
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } rx_state_e;

  localparam int DATA_BITS         = 8;
  localparam int DEF_OVERSAMPLE    = 16;
  localparam int DEF_CLKS_PER_TICK = 2;

endpackage

// File: rtl/baud_tick_gen.sv
// rtl/baud_tick_gen.sv - free-running divider giving a one-clk oversample tick
module baud_tick_gen #(
  parameter int CLKS_PER_TICK = 2
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int CW = (CLKS_PER_TICK > 1) ? $clog2(CLKS_PER_TICK) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_TICK - 1);

  logic [CW-1:0] cnt;

  // Wrap the divider at CLKS_PER_TICK-1; the tick marks the wrap cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tick = (cnt == CNT_LAST);

endmodule

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - 8N1 oversampling receiver with FWFT byte FIFO; stop-bit check under UART_RX_FRAME_CHECK_EN
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int CLKS_PER_TICK = DEF_CLKS_PER_TICK,
  parameter int OVERSAMPLE    = DEF_OVERSAMPLE,
  parameter int FIFO_AW       = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx,
  input  logic                 rd_en,
  output logic [DATA_BITS-1:0] rd_data,
  output logic                 rx_empty,
  output logic                 rx_full,
  output logic                 overrun,
  output logic                 frame_err
);

  localparam int SW    = $clog2(OVERSAMPLE);
  localparam int NW    = $clog2(DATA_BITS);
  localparam int DEPTH = 1 << FIFO_AW;

  localparam logic [SW-1:0] S_MID  = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] S_LAST = SW'(OVERSAMPLE - 1);
  localparam logic [NW-1:0] N_LAST = NW'(DATA_BITS - 1);

  logic rx_meta;
  logic rxs;
  logic tick;

  rx_state_e            state, state_n;
  logic [SW-1:0]        s, s_n;
  logic [NW-1:0]        n, n_n;
  logic [DATA_BITS-1:0] b, b_n;
  logic                 stop_sample;
  logic                 push_req;

  logic [DATA_BITS-1:0] mem [DEPTH];
  logic [FIFO_AW:0]     wr_ptr;
  logic [FIFO_AW:0]     rd_ptr;
  logic                 do_push;
  logic                 do_pop;

  // Two-flop synchronizer; both stages idle high so reset never looks like a start bit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= rx;
      rxs     <= rx_meta;
    end
  end

  baud_tick_gen #(
    .CLKS_PER_TICK(CLKS_PER_TICK)
  ) u_tick (
    .clk  (clk),
    .reset(reset),
    .tick (tick)
  );

  // Receiver state, tick count, bit count and shift register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
      s     <= '0;
      n     <= '0;
      b     <= '0;
    end else begin
      state <= state_n;
      s     <= s_n;
      n     <= n_n;
      b     <= b_n;
    end
  end

  // Deframing: align on the start-bit centre, then sample once per bit time.
  always_comb begin
    state_n     = state;
    s_n         = s;
    n_n         = n;
    b_n         = b;
    stop_sample = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!rxs) begin
          state_n = ST_START;
          s_n     = '0;
        end
      end
      ST_START: begin
        if (tick) begin
          if (s == S_MID) begin
            if (!rxs) begin
              state_n = ST_DATA;
              s_n     = '0;
              n_n     = '0;
            end else begin
              state_n = ST_IDLE;
            end
          end else begin
            s_n = s + SW'(1);
          end
        end
      end
      ST_DATA: begin
        if (tick) begin
          if (s == S_LAST) begin
            b_n = {rxs, b[DATA_BITS-1:1]};
            s_n = '0;
            n_n = n + NW'(1);
            if (n == N_LAST) begin
              state_n = ST_STOP;
            end
          end else begin
            s_n = s + SW'(1);
          end
        end
      end
      ST_STOP: begin
        if (tick) begin
          if (s == S_LAST) begin
            stop_sample = 1'b1;
            state_n     = ST_IDLE;
          end else begin
            s_n = s + SW'(1);
          end
        end
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

`ifdef UART_RX_FRAME_CHECK_EN
  logic frame_err_q;

  assign push_req = stop_sample && rxs;

  // A low stop bit drops the byte and flags it for one cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      frame_err_q <= 1'b0;
    end else begin
      frame_err_q <= stop_sample && !rxs;
    end
  end

  assign frame_err = frame_err_q;
`else
  assign push_req  = stop_sample;
  assign frame_err = 1'b0;
`endif

  assign rx_empty = (wr_ptr == rd_ptr);
  assign rx_full  = (wr_ptr[FIFO_AW] != rd_ptr[FIFO_AW]) &&
                    (wr_ptr[FIFO_AW-1:0] == rd_ptr[FIFO_AW-1:0]);
  assign rd_data  = mem[rd_ptr[FIFO_AW-1:0]];

  // A pop in the same cycle frees the slot, so a push into a full FIFO can still land.
  assign do_pop  = rd_en && !rx_empty;
  assign do_push = push_req && (!rx_full || do_pop);

  // FIFO storage is not reset; contents are only visible through non-empty pointers.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr[FIFO_AW-1:0]] <= b;
    end
  end

  // Pointer update and overrun pulse for bytes that found no room.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      overrun <= 1'b0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + (FIFO_AW + 1)'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + (FIFO_AW + 1)'(1);
      end
      overrun <= push_req && rx_full && !do_pop;
    end
  end

endmodule
